// File: rtl/kf8259_common_pkg.sv
// Shared types, state codes and priority helpers for the KF8259 sequencer.
package kf8259_common_pkg;

   localparam int unsigned IRQ_W   = 8;
   localparam int unsigned LEVEL_W = 3;
   localparam int unsigned BASE_W  = 5;
   localparam int unsigned STATE_W = 3;

   // Sequencer states; kept as plain constants so older tools see the same encoding.
   localparam logic [STATE_W-1:0] STATE_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] STATE_REQ   = 3'd1;
   localparam logic [STATE_W-1:0] STATE_ACK1  = 3'd2;
   localparam logic [STATE_W-1:0] STATE_WAIT2 = 3'd3;
   localparam logic [STATE_W-1:0] STATE_ACK2  = 3'd4;

   // Result bit i takes value bit (i + amount) mod 8.
   function automatic logic [IRQ_W-1:0] rotate_right(input logic [IRQ_W-1:0]   value,
                                                     input logic [LEVEL_W-1:0] amount);
      logic [2*IRQ_W-1:0] doubled;
      doubled = {value, value};
      return doubled[amount +: IRQ_W];
   endfunction

   // One-hot of the lowest set bit (zero when nothing is set).
   function automatic logic [IRQ_W-1:0] resolve_priority(input logic [IRQ_W-1:0] bits);
      return bits & IRQ_W'(~bits + IRQ_W'(1));
   endfunction

   // Index of the set bit in a one-hot vector.
   function automatic logic [LEVEL_W-1:0] onehot_to_level(input logic [IRQ_W-1:0] onehot);
      logic [LEVEL_W-1:0] level;
      level = '0;
      for (int i = 0; i < int'(IRQ_W); i++) begin
         if (onehot[i]) level = level | LEVEL_W'(i);
      end
      return level;
   endfunction

endpackage

// File: rtl/kf8259_priority_resolver.sv
// Picks the highest-priority set bit under the current rotating priority.
module kf8259_priority_resolver
   import kf8259_common_pkg::*;
(
   input  logic [LEVEL_W-1:0] lowest_priority_level_i,
   input  logic [IRQ_W-1:0]   request_i,
   output logic [IRQ_W-1:0]   grant_c_o
);

   logic [LEVEL_W-1:0] amount_c;
   logic [IRQ_W-1:0]   rotated_c;
   logic [IRQ_W-1:0]   resolved_c;

   // Bring the highest-priority level to bit 0, take the lowest set bit, rotate back.
   always_comb begin
      amount_c   = LEVEL_W'(lowest_priority_level_i + LEVEL_W'(1));
      rotated_c  = rotate_right(request_i, amount_c);
      resolved_c = resolve_priority(rotated_c);
      grant_c_o  = rotate_right(resolved_c, LEVEL_W'(LEVEL_W'(0) - amount_c));
   end

endmodule

// File: rtl/kf8259_interrupt_sequencer.sv
// Priority resolution, INT generation, 8086 INTA handshake and EOI handling.
module kf8259_interrupt_sequencer
   import kf8259_common_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic [IRQ_W-1:0]   interrupt_request_register,
   input  logic [IRQ_W-1:0]   interrupt_mask,
   input  logic [BASE_W-1:0]  interrupt_vector_base,
   input  logic               auto_eoi_config,
   input  logic               rotate_on_aeoi,
   input  logic               interrupt_acknowledge_n,
   input  logic               eoi_request,
   input  logic               eoi_specific,
   input  logic [LEVEL_W-1:0] eoi_level,
   input  logic               eoi_rotate,
   output logic               interrupt_to_cpu,
   output logic               freeze,
   output logic [IRQ_W-1:0]   clear_interrupt_request,
   output logic [IRQ_W-1:0]   in_service_register,
   output logic [IRQ_W-1:0]   interrupt_vector,
   output logic               vector_valid,
   output logic [LEVEL_W-1:0] lowest_priority_level
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               int_q, int_d;
   logic               freeze_q, freeze_d;
   logic [IRQ_W-1:0]   clear_q, clear_d;
   logic [IRQ_W-1:0]   isr_q, isr_d;
   logic [IRQ_W-1:0]   vector_q, vector_d;
   logic               valid_q, valid_d;
   logic [LEVEL_W-1:0] lowest_q, lowest_d;
   logic [LEVEL_W-1:0] ack_level_q, ack_level_d;
   logic               spurious_q, spurious_d;
   logic               inta_prev_q;

   logic [IRQ_W-1:0]   eligible_c;
   logic [IRQ_W-1:0]   pending_onehot_c;
   logic [IRQ_W-1:0]   isr_top_onehot_c;
   logic [LEVEL_W-1:0] pending_level_c;
   logic [LEVEL_W-1:0] isr_top_level_c;
   logic               pending_valid_c;
   logic               ack_fall_c;
   logic [LEVEL_W-1:0] eoi_clear_level_c;
   logic               eoi_active_c;

   assign eligible_c = interrupt_request_register & ~interrupt_mask;

   kf8259_priority_resolver u_request_resolver (
      .lowest_priority_level_i (lowest_q),
      .request_i               (eligible_c),
      .grant_c_o               (pending_onehot_c)
   );

   kf8259_priority_resolver u_service_resolver (
      .lowest_priority_level_i (lowest_q),
      .request_i               (isr_q),
      .grant_c_o               (isr_top_onehot_c)
   );

   // Fully nested check: a request only counts if it outranks everything in service.
   always_comb begin
      pending_level_c   = onehot_to_level(pending_onehot_c);
      isr_top_level_c   = onehot_to_level(isr_top_onehot_c);
      pending_valid_c   = (eligible_c != '0) &&
                          ((isr_q == '0) ||
                           (LEVEL_W'(pending_level_c - lowest_q - LEVEL_W'(1)) <
                            LEVEL_W'(isr_top_level_c - lowest_q - LEVEL_W'(1))));
      ack_fall_c        = inta_prev_q & ~interrupt_acknowledge_n;
      eoi_clear_level_c = eoi_specific ? eoi_level : isr_top_level_c;
      eoi_active_c      = eoi_request && (eoi_specific || (isr_q != '0));
   end

   // Next-state logic: EOI first on the old ISR, then the handshake, so a set wins.
   always_comb begin
      state_d     = state_q;
      int_d       = int_q;
      freeze_d    = freeze_q;
      clear_d     = '0;
      isr_d       = isr_q;
      vector_d    = vector_q;
      valid_d     = valid_q;
      lowest_d    = lowest_q;
      ack_level_d = ack_level_q;
      spurious_d  = spurious_q;

      if (eoi_active_c) begin
         isr_d[eoi_clear_level_c] = 1'b0;
         if (eoi_rotate) lowest_d = eoi_clear_level_c;
      end

      case (state_q)
         STATE_IDLE: begin
            if (pending_valid_c) begin
               state_d = STATE_REQ;
               int_d   = 1'b1;
            end
         end
         STATE_REQ: begin
            if (ack_fall_c) begin
               state_d  = STATE_ACK1;
               int_d    = 1'b0;
               freeze_d = 1'b1;
               if (pending_valid_c) begin
                  ack_level_d            = pending_level_c;
                  spurious_d             = 1'b0;
                  isr_d[pending_level_c] = 1'b1;
                  clear_d                = pending_onehot_c;
               end else begin
                  ack_level_d = LEVEL_W'(7);
                  spurious_d  = 1'b1;
               end
            end else if (!pending_valid_c) begin
               state_d = STATE_IDLE;
               int_d   = 1'b0;
            end
         end
         STATE_ACK1: begin
            if (interrupt_acknowledge_n) state_d = STATE_WAIT2;
         end
         STATE_WAIT2: begin
            if (ack_fall_c) begin
               state_d  = STATE_ACK2;
               vector_d = {interrupt_vector_base, ack_level_q};
               valid_d  = 1'b1;
            end
         end
         STATE_ACK2: begin
            if (interrupt_acknowledge_n) begin
               state_d  = STATE_IDLE;
               valid_d  = 1'b0;
               freeze_d = 1'b0;
               if (auto_eoi_config && !spurious_q) isr_d[ack_level_q] = 1'b0;
               if (auto_eoi_config && rotate_on_aeoi) lowest_d = ack_level_q;
            end
         end
         default: begin
            state_d = STATE_IDLE;
            int_d   = 1'b0;
         end
      endcase
   end

   // State and output registers, updated on the falling clock edge.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= STATE_IDLE;
         int_q       <= 1'b0;
         freeze_q    <= 1'b0;
         clear_q     <= '0;
         isr_q       <= '0;
         vector_q    <= '0;
         valid_q     <= 1'b0;
         lowest_q    <= LEVEL_W'(7);
         ack_level_q <= '0;
         spurious_q  <= 1'b0;
         inta_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         int_q       <= int_d;
         freeze_q    <= freeze_d;
         clear_q     <= clear_d;
         isr_q       <= isr_d;
         vector_q    <= vector_d;
         valid_q     <= valid_d;
         lowest_q    <= lowest_d;
         ack_level_q <= ack_level_d;
         spurious_q  <= spurious_d;
         inta_prev_q <= interrupt_acknowledge_n;
      end
   end

   assign interrupt_to_cpu        = int_q;
   assign freeze                  = freeze_q;
   assign clear_interrupt_request = clear_q;
   assign in_service_register     = isr_q;
   assign interrupt_vector        = vector_q;
   assign vector_valid            = valid_q;
   assign lowest_priority_level   = lowest_q;

endmodule

// File: tb/tb_kf8259_interrupt_sequencer.sv
// Bench for the KF8259 interrupt sequencer: directed vector table, reset sequence, random run.
module tb_kf8259_interrupt_sequencer;

   logic       clock;
   logic       reset_n;
   logic [7:0] irr, imr;
   logic [4:0] base;
   logic       aeoi, rot_aeoi, inta_n, eoi_req, eoi_spec, eoi_rot;
   logic [2:0] eoi_lvl;
   logic       int_o, freeze_o, valid_o;
   logic [7:0] clear_o, isr_o, vec_o;
   logic [2:0] lpl_o;

   int errors = 0;
   int checks = 0;

   kf8259_interrupt_sequencer dut (
      .clock                      (clock),
      .reset_n                    (reset_n),
      .interrupt_request_register (irr),
      .interrupt_mask             (imr),
      .interrupt_vector_base      (base),
      .auto_eoi_config            (aeoi),
      .rotate_on_aeoi             (rot_aeoi),
      .interrupt_acknowledge_n    (inta_n),
      .eoi_request                (eoi_req),
      .eoi_specific               (eoi_spec),
      .eoi_level                  (eoi_lvl),
      .eoi_rotate                 (eoi_rot),
      .interrupt_to_cpu           (int_o),
      .freeze                     (freeze_o),
      .clear_interrupt_request    (clear_o),
      .in_service_register        (isr_o),
      .interrupt_vector           (vec_o),
      .vector_valid               (valid_o),
      .lowest_priority_level      (lpl_o)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] irr, imr;
      logic       inta_n, aeoi, rot, eoi, spec;
      logic [2:0] elvl;
      logic       erot;
      logic       e_int, e_frz;
      logic [7:0] e_clr, e_isr, e_vec;
      logic       e_val;
      logic [2:0] e_lpl;
   } vec_t;

   localparam int NVEC = 38;
   vec_t tbl[NVEC];

   function automatic vec_t mk(logic [7:0] i_irr, logic [7:0] i_imr, logic i_inta, logic i_aeoi,
                               logic i_rot, logic i_eoi, logic i_spec, logic [2:0] i_elvl,
                               logic i_erot, logic x_int, logic x_frz, logic [7:0] x_clr,
                               logic [7:0] x_isr, logic [7:0] x_vec, logic x_val, logic [2:0] x_lpl);
      vec_t v;
      v.irr = i_irr; v.imr = i_imr; v.inta_n = i_inta; v.aeoi = i_aeoi; v.rot = i_rot;
      v.eoi = i_eoi; v.spec = i_spec; v.elvl = i_elvl; v.erot = i_erot;
      v.e_int = x_int; v.e_frz = x_frz; v.e_clr = x_clr; v.e_isr = x_isr; v.e_vec = x_vec;
      v.e_val = x_val; v.e_lpl = x_lpl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic x_int, input logic x_frz,
                          input logic [7:0] x_clr, input logic [7:0] x_isr, input logic [7:0] x_vec,
                          input logic x_val, input logic [2:0] x_lpl);
      chk({tag, " int"},    8'(int_o),    8'(x_int));
      chk({tag, " freeze"}, 8'(freeze_o), 8'(x_frz));
      chk({tag, " clear"},  clear_o,      x_clr);
      chk({tag, " isr"},    isr_o,        x_isr);
      chk({tag, " vector"}, vec_o,        x_vec);
      chk({tag, " valid"},  8'(valid_o),  8'(x_val));
      chk({tag, " lpl"},    8'(lpl_o),    8'(x_lpl));
   endtask

   // Behavioural reference: priorities found by searching outward from the bottom level.
   int         m_phase;          // 0 idle, 1 int raised, 2 first ack, 3 wait second, 4 second ack
   logic       m_int, m_frz, m_val, m_prev_inta, m_spur;
   logic [7:0] m_clr, m_isr, m_vec;
   int         m_lpl, m_ack;

   function automatic int top_level(logic [7:0] bits, int lpl);
      for (int k = 1; k <= 8; k++) begin
         int lvl;
         lvl = (lpl + k) % 8;
         if (bits[lvl]) return lvl;
      end
      return -1;
   endfunction

   function automatic int rank(int lvl, int lpl);
      return (lvl - lpl - 1 + 16) % 8;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_int = 0; m_frz = 0; m_val = 0; m_prev_inta = 1; m_spur = 0;
      m_clr = 0; m_isr = 0; m_vec = 0; m_lpl = 7; m_ack = 0;
   endtask

   task automatic model_step();
      int         pend, top, lvl;
      logic       pv, fall;
      logic [7:0] n_isr;
      int         n_lpl;
      pend  = top_level(irr & ~imr, m_lpl);
      top   = top_level(m_isr, m_lpl);
      pv    = (pend >= 0) && ((top < 0) || (rank(pend, m_lpl) < rank(top, m_lpl)));
      fall  = m_prev_inta && !inta_n;
      n_isr = m_isr;
      n_lpl = m_lpl;
      m_clr = 8'h00;
      if (eoi_req) begin
         lvl = eoi_spec ? int'(eoi_lvl) : top;
         if (lvl >= 0) begin
            n_isr[lvl] = 1'b0;
            if (eoi_rot) n_lpl = lvl;
         end
      end
      if (m_phase == 0) begin
         if (pv) begin m_phase = 1; m_int = 1; end
      end else if (m_phase == 1) begin
         if (fall) begin
            m_phase = 2; m_int = 0; m_frz = 1;
            if (pv) begin
               m_ack = pend; m_spur = 0; n_isr[pend] = 1'b1; m_clr = 8'(1 << pend);
            end else begin
               m_ack = 7; m_spur = 1;
            end
         end else if (!pv) begin
            m_phase = 0; m_int = 0;
         end
      end else if (m_phase == 2) begin
         if (inta_n) m_phase = 3;
      end else if (m_phase == 3) begin
         if (fall) begin
            m_phase = 4; m_vec = {base, 3'(m_ack)}; m_val = 1;
         end
      end else begin
         if (inta_n) begin
            m_phase = 0; m_val = 0; m_frz = 0;
            if (aeoi && !m_spur) n_isr[m_ack] = 1'b0;
            if (aeoi && rot_aeoi) n_lpl = m_ack;
         end
      end
      m_isr = n_isr;
      m_lpl = n_lpl;
      m_prev_inta = inta_n;
   endtask

   task automatic idle_inputs();
      irr = 0; imr = 0; inta_n = 1; eoi_req = 0; eoi_spec = 0; eoi_lvl = 0; eoi_rot = 0;
   endtask

   initial begin
      reset_n = 0; base = 5'b00001; aeoi = 0; rot_aeoi = 0;
      idle_inputs();

      // Directed scenarios: single request, nesting, mask, IDLE INTA, spurious, AEOI rotation.
      tbl[0]  = mk(8'h08,8'h00,1,0,0,0,0,0,0, 1,0,8'h00,8'h00,8'h00,0,7);
      tbl[1]  = mk(8'h08,8'h00,0,0,0,0,0,0,0, 0,1,8'h08,8'h08,8'h00,0,7);
      tbl[2]  = mk(8'h00,8'h00,1,0,0,0,0,0,0, 0,1,8'h00,8'h08,8'h00,0,7);
      tbl[3]  = mk(8'h00,8'h00,0,0,0,0,0,0,0, 0,1,8'h00,8'h08,8'h0B,1,7);
      tbl[4]  = mk(8'h00,8'h00,1,0,0,0,0,0,0, 0,0,8'h00,8'h08,8'h0B,0,7);
      tbl[5]  = mk(8'h00,8'h00,1,0,0,1,0,0,0, 0,0,8'h00,8'h00,8'h0B,0,7);
      tbl[6]  = mk(8'h20,8'h00,1,0,0,0,0,0,0, 1,0,8'h00,8'h00,8'h0B,0,7);
      tbl[7]  = mk(8'h20,8'h00,0,0,0,0,0,0,0, 0,1,8'h20,8'h20,8'h0B,0,7);
      tbl[8]  = mk(8'h00,8'h00,1,0,0,0,0,0,0, 0,1,8'h00,8'h20,8'h0B,0,7);
      tbl[9]  = mk(8'h00,8'h00,0,0,0,0,0,0,0, 0,1,8'h00,8'h20,8'h0D,1,7);
      tbl[10] = mk(8'h00,8'h00,1,0,0,0,0,0,0, 0,0,8'h00,8'h20,8'h0D,0,7);
      tbl[11] = mk(8'h40,8'h00,1,0,0,0,0,0,0, 0,0,8'h00,8'h20,8'h0D,0,7);
      tbl[12] = mk(8'h44,8'h00,1,0,0,0,0,0,0, 1,0,8'h00,8'h20,8'h0D,0,7);
      tbl[13] = mk(8'h44,8'h00,0,0,0,0,0,0,0, 0,1,8'h04,8'h24,8'h0D,0,7);
      tbl[14] = mk(8'h40,8'h00,1,0,0,0,0,0,0, 0,1,8'h00,8'h24,8'h0D,0,7);
      tbl[15] = mk(8'h40,8'h00,0,0,0,0,0,0,0, 0,1,8'h00,8'h24,8'h0A,1,7);
      tbl[16] = mk(8'h40,8'h00,1,0,0,0,0,0,0, 0,0,8'h00,8'h24,8'h0A,0,7);
      tbl[17] = mk(8'h40,8'h00,1,0,0,1,0,0,0, 0,0,8'h00,8'h20,8'h0A,0,7);
      tbl[18] = mk(8'h00,8'h00,1,0,0,1,1,5,0, 0,0,8'h00,8'h00,8'h0A,0,7);
      tbl[19] = mk(8'h10,8'h10,0,0,0,0,0,0,0, 0,0,8'h00,8'h00,8'h0A,0,7);
      tbl[20] = mk(8'h10,8'h00,1,0,0,0,0,0,0, 1,0,8'h00,8'h00,8'h0A,0,7);
      tbl[21] = mk(8'h00,8'h00,0,0,0,0,0,0,0, 0,1,8'h00,8'h00,8'h0A,0,7);
      tbl[22] = mk(8'h00,8'h00,1,0,0,0,0,0,0, 0,1,8'h00,8'h00,8'h0A,0,7);
      tbl[23] = mk(8'h00,8'h00,0,0,0,0,0,0,0, 0,1,8'h00,8'h00,8'h0F,1,7);
      tbl[24] = mk(8'h00,8'h00,1,0,0,0,0,0,0, 0,0,8'h00,8'h00,8'h0F,0,7);
      tbl[25] = mk(8'h02,8'h00,1,1,1,0,0,0,0, 1,0,8'h00,8'h00,8'h0F,0,7);
      tbl[26] = mk(8'h02,8'h00,0,1,1,0,0,0,0, 0,1,8'h02,8'h02,8'h0F,0,7);
      tbl[27] = mk(8'h00,8'h00,1,1,1,0,0,0,0, 0,1,8'h00,8'h02,8'h0F,0,7);
      tbl[28] = mk(8'h00,8'h00,0,1,1,0,0,0,0, 0,1,8'h00,8'h02,8'h09,1,7);
      tbl[29] = mk(8'h00,8'h00,1,1,1,0,0,0,0, 0,0,8'h00,8'h00,8'h09,0,1);
      tbl[30] = mk(8'h05,8'h00,1,1,1,0,0,0,0, 1,0,8'h00,8'h00,8'h09,0,1);
      tbl[31] = mk(8'h05,8'h00,0,1,1,0,0,0,0, 0,1,8'h04,8'h04,8'h09,0,1);
      tbl[32] = mk(8'h01,8'h00,1,1,1,0,0,0,0, 0,1,8'h00,8'h04,8'h09,0,1);
      tbl[33] = mk(8'h01,8'h00,0,1,1,0,0,0,0, 0,1,8'h00,8'h04,8'h0A,1,1);
      tbl[34] = mk(8'h01,8'h00,1,1,1,0,0,0,0, 0,0,8'h00,8'h00,8'h0A,0,2);
      tbl[35] = mk(8'h01,8'h00,1,1,1,0,0,0,0, 1,0,8'h00,8'h00,8'h0A,0,2);
      tbl[36] = mk(8'h01,8'h00,0,1,1,0,0,0,0, 0,1,8'h01,8'h01,8'h0A,0,2);
      tbl[37] = mk(8'h00,8'h00,1,1,1,0,0,0,0, 0,1,8'h00,8'h01,8'h0A,0,2);

      #12;
      chk_all("reset", 0, 0, 8'h00, 8'h00, 8'h00, 0, 7);
      @(posedge clock);
      reset_n = 1;

      for (int i = 0; i < NVEC; i++) begin
         irr = tbl[i].irr; imr = tbl[i].imr; inta_n = tbl[i].inta_n;
         aeoi = tbl[i].aeoi; rot_aeoi = tbl[i].rot; eoi_req = tbl[i].eoi;
         eoi_spec = tbl[i].spec; eoi_lvl = tbl[i].elvl; eoi_rot = tbl[i].erot;
         @(negedge clock);
         @(posedge clock);
         chk_all($sformatf("row%0d", i), tbl[i].e_int, tbl[i].e_frz, tbl[i].e_clr,
                 tbl[i].e_isr, tbl[i].e_vec, tbl[i].e_val, tbl[i].e_lpl);
      end

      // Asynchronous reset while waiting for the second INTA#.
      reset_n = 0;
      #1;
      chk_all("async_reset", 0, 0, 8'h00, 8'h00, 8'h00, 0, 7);
      idle_inputs();
      aeoi = 0; rot_aeoi = 0;
      @(negedge clock);
      @(posedge clock);
      reset_n = 1;
      @(negedge clock);
      @(posedge clock);
      chk_all("post_reset", 0, 0, 8'h00, 8'h00, 8'h00, 0, 7);
      irr = 8'h01;
      @(negedge clock);
      @(posedge clock);
      chk_all("post_reset_req", 1, 0, 8'h00, 8'h00, 8'h00, 0, 7);

      // Randomized run against the reference model.
      reset_n = 0;
      idle_inputs();
      model_reset();
      @(negedge clock);
      @(posedge clock);
      reset_n = 1;
      for (int c = 0; c < 1500; c++) begin
         if (c % 64 == 0) begin
            base     = 5'($urandom);
            aeoi     = 1'($urandom_range(0, 1));
            rot_aeoi = 1'($urandom_range(0, 1));
         end
         irr      = 8'($urandom) & 8'($urandom);
         imr      = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
         inta_n   = 1'($urandom_range(0, 1));
         eoi_req  = ($urandom_range(0, 7) == 0);
         eoi_spec = 1'($urandom_range(0, 1));
         eoi_lvl  = 3'($urandom);
         eoi_rot  = ($urandom_range(0, 3) == 0);
         @(negedge clock);
         model_step();
         @(posedge clock);
         chk_all($sformatf("rand%0d", c), m_int, m_frz, m_clr, m_isr, m_vec, m_val, 3'(m_lpl));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kf8259_interrupt_sequencer.md
# kf8259_interrupt_sequencer

Priority resolver and INTA sequencer for the KF8259 PIC. It sits between the interrupt-request latch and the CPU bus interface. It picks the highest-priority unmasked request against the in-service register, drives INT, and runs the two-pulse 8086 INTA handshake. During that handshake it freezes and clears the request latch, sets and clears in-service bits, and presents the vector byte. EOI commands from the control logic are also handled here.

## Interface
- Parameters: none.
- `clock` in 1: single clock. All state updates on the falling edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `interrupt_request_register` in 8: IRR from the request latch.
- `interrupt_mask` in 8: IMR; 1 = masked.
- `interrupt_vector_base` in 5: T7..T3 of the vector.
- `auto_eoi_config` in 1: AEOI mode.
- `rotate_on_aeoi` in 1: rotate priority on automatic EOI.
- `interrupt_acknowledge_n` in 1: INTA# pin, sampled on the falling edge.
- `eoi_request` in 1: one-cycle EOI command strobe.
- `eoi_specific` in 1: 1 = specific EOI using `eoi_level`.
- `eoi_level` in 3: level for a specific EOI.
- `eoi_rotate` in 1: set lowest priority to the cleared level.
- `interrupt_to_cpu` out 1: INT.
- `freeze` out 1: hold the request latch.
- `clear_interrupt_request` out 8: one-hot, one-cycle IRR clear.
- `in_service_register` out 8: ISR.
- `interrupt_vector` out 8: vector byte.
- `vector_valid` out 1: bus-interface drive enable.
- `lowest_priority_level` out 3: current bottom-priority level.

## Operation
- Priority order: the level after `lowest_priority_level` is highest, wrapping modulo 8. Reset value 7, so IR0 is highest.
- `eligible = IRR & ~IMR`. `pending` = highest-priority eligible level.
- `pending_valid` is true when `eligible` ≠ 0 and `pending` has strictly higher priority than the highest ISR bit, or ISR = 0 (fully nested).
- `ack_fall` = registered previous INTA# (reset 1) & ~INTA#.
- FSM states: IDLE, REQ, ACK1, WAIT2, ACK2.
- **IDLE**
  - `pending_valid` → REQ; INT = 1.
- **REQ**
  - `ack_fall` → ACK1.
    - If `pending_valid`: latch `ack_level = pending`; set ISR[ack_level]; pulse `clear_interrupt_request[ack_level]` for one cycle.
    - Otherwise (spurious): `ack_level` = 7, ISR unchanged, no clear.
    - In both cases: INT = 0, `freeze` = 1.
  - `!pending_valid` and no `ack_fall` → IDLE; INT = 0.
- **ACK1**
  - INTA# high → WAIT2.
- **WAIT2**
  - `ack_fall` → ACK2; `interrupt_vector = {base, ack_level}`; `vector_valid` = 1.
- **ACK2**
  - INTA# high → IDLE; `vector_valid` = 0; `freeze` = 0.
  - If AEOI and not spurious: clear ISR[ack_level].
  - If AEOI and `rotate_on_aeoi`: `lowest_priority_level = ack_level`.
- **EOI** (on `eoi_request`, any state)
  - Non-specific: clear the highest-priority ISR bit.
  - Specific: clear ISR[eoi_level].
  - `eoi_rotate`: `lowest_priority_level` = the cleared level.
  - Non-specific EOI with ISR = 0 is a no-op, with no rotation.
- **Simultaneous events**
  - EOI is computed on the pre-update ISR.
  - If an EOI clear and an ACK1 set hit the same bit in the same cycle, the set wins.
- **INTA# pulses in IDLE** are ignored; no state change.

## Timing
- Reset values:
  - INT, `freeze`, `vector_valid`: 0.
  - `clear_interrupt_request`, ISR, `interrupt_vector`: 0.
  - `lowest_priority_level`: 7.
  - FSM: IDLE.
- INT rises one falling edge after `pending_valid` becomes true.
- INT falls on the edge that samples the first INTA# low.
- The clear pulse is exactly one cycle wide, on the ACK1 entry edge.
- The vector is registered and valid from the edge that samples the second INTA# low until the edge that samples INTA# high.
- `reset_n` low in any state returns all outputs to reset values immediately (asynchronous), including mid-handshake.

## Structure
- Shared package `kf8259_common_pkg`:
  - State enum.
  - Function `rotate_right(value[7:0], amount[2:0])`.
  - Function `resolve_priority(bits[7:0])` returning a one-hot of the lowest set bit.
  - Function `onehot_to_level`.
- Sub-module `kf8259_priority_resolver`: combinational; rotates by `lowest_priority_level`, resolves, and un-rotates. Instantiated twice, once for eligible requests and once for ISR.

## Test plan
- **Single request.** IRR = 0x08, base = 5'b00001.
  - INT = 1 next edge.
  - First INTA → ISR = 0x08, clear = 0x08 for one cycle, INT = 0.
  - Second INTA → vector 0x0B.
  - Non-specific EOI → ISR = 0x00.
- **Nesting.** ISR = 0x20, then IRR = 0x40 → INT stays 0. Then IRR = 0x44 → INT = 1, and the ack sets ISR = 0x24.
- **Mask.** IRR = 0x10, IMR = 0x10 → INT 0. IMR = 0x00 → INT = 1 one edge later.
- **Spurious.** IR4 request; IRR drops on the same edge INTA# first falls → vector = {base, 3'b111}, ISR unchanged, no clear pulse.
- **AEOI with rotation.** AEOI = 1, rotate = 1, IR1 acked → ISR 0x00 after the second INTA, `lowest_priority_level` = 1. Then IRR = 0x05 → IR2 acked first.
- **Reset mid-handshake.** `reset_n` low in WAIT2 → INT, `freeze`, `vector_valid`, ISR all 0 without waiting for a clock edge; after release, FSM is IDLE with `lowest_priority_level` = 7.
